mudi_iter: RTL and testbench

// - Parametrised multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// - Replaces the fixed 32-bit mudi. Busy time is set by parameters; the divider is iterative at 1 bit/cycle.
// - Adds a done pulse, defined divide-by-zero and overflow results, and optional multiply-accumulate.
// - The hazard unit stalls D on (start | busy) whenever an HI/LO-touching instruction sits in D.

---
 rtl/mudi_iter.sv | 209 ++++++++++++++++++++
 tb/tb_mudi_iter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mudi_iter.sv
// mudi_iter: multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Multiply has a fixed visible latency of MUL_LAT cycles. Divide is restoring,
// 1 quotient bit per cycle, WIDTH cycles. Optional multiply-accumulate is
// enabled by defining MUDI_MADD_EN; without it ops 8..11 are no-ops.
module mudi_iter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] Din,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] Dout
);

    localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MFHI  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd8;
    localparam logic [3:0] OP_MADDU = 4'd9;
    localparam logic [3:0] OP_MSUB  = 4'd10;
    localparam logic [3:0] OP_MSUBU = 4'd11;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              done_q, done_d;

    // Signed variants (MULT, DIV, MADD, MSUB) all have an even opcode.
    logic              sgn_q, sgn_in;
    logic              start_mul, start_div;

    logic [2*WIDTH-1:0] a_ext, b_ext, prod, mul_res;
    logic [WIDTH-1:0]   b_mag, rem_nx, quo_nx, q_fix, r_fix;
    logic [WIDTH:0]     rem_sh, diff;
    logic               take;

    assign sgn_q  = ~op_q[0];
    assign sgn_in = ~op[0];

    // Decode which ops launch a multi-cycle operation.
    always_comb begin
        start_div = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MUDI_MADD_EN
        start_mul = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
                    (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`else
        start_mul = (op == OP_MULT) || (op == OP_MULTU);
`endif
    end

    // Full product from the latched operands, optionally folded into HI/LO.
    always_comb begin
        a_ext = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
        b_ext = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
        prod  = a_ext * b_ext;
        mul_res = prod;
`ifdef MUDI_MADD_EN
        if ((op_q == OP_MADD) || (op_q == OP_MADDU))
            mul_res = {hi_q, lo_q} + prod;
        else if ((op_q == OP_MSUB) || (op_q == OP_MSUBU))
            mul_res = {hi_q, lo_q} - prod;
`endif
    end

    // One restoring-division step on magnitudes plus final sign fix.
    always_comb begin
        b_mag  = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, b_mag};
        take   = (rem_sh >= {1'b0, b_mag});
        rem_nx = take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], take};
        q_fix  = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_nx : quo_nx;
        r_fix  = (sgn_q && a_q[WIDTH-1]) ? -rem_nx : rem_nx;
    end

    // Next-state logic: flush dominates, then per-state behaviour.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (start_mul) begin
                            state_d = S_MUL;
                            cnt_d   = CW'(MUL_LAT - 1);
                            op_d    = op;
                            a_d     = A;
                            b_d     = B;
                        end else if (start_div) begin
                            state_d = S_DIV;
                            cnt_d   = CW'(WIDTH - 1);
                            op_d    = op;
                            a_d     = A;
                            b_d     = B;
                            rem_d   = '0;
                            quo_d   = (sgn_in && A[WIDTH-1]) ? -A : A;
                        end else if (op == OP_MTHI) begin
                            hi_d = Din;
                        end else if (op == OP_MTLO) begin
                            lo_d = Din;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        {hi_d, lo_d} = mul_res;
                        state_d      = S_IDLE;
                        done_d       = 1'b1;
                    end
                end
                S_DIV: begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        // Divide by zero yields all-ones quotient and the raw dividend.
                        if (b_q == '0) begin
                            lo_d = '1;
                            hi_d = a_q;
                        end else begin
                            lo_d = q_fix;
                            hi_d = r_fix;
                        end
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign Dout = (op == OP_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mudi_iter.sv
// Self-checking bench for mudi_iter: directed corner cases plus randomized ops
// compared against an arithmetic reference model of HI/LO.
module tb_mudi_iter;

    localparam int W   = 32;
    localparam int LAT = 5;

    logic          Clk, Reset_n, start, flush;
    logic [3:0]    op;
    logic [W-1:0]  A, B, Din;
    logic          busy, done;
    logic [W-1:0]  hi, lo, Dout;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [31:0]   exp_hi, exp_lo;

    mudi_iter #(.WIDTH(W), .MUL_LAT(LAT)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .op(op),
        .A(A), .B(B), .Din(Din), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .Dout(Dout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: new HI/LO and busy length from the op's arithmetic meaning.
    task automatic model_op(input logic [3:0] o, input logic [31:0] a, b, d,
                            output logic [31:0] nh, nl, output int lat);
        logic [63:0] p, acc;
        longint sa, sb, q, r;
        nh = exp_hi; nl = exp_lo; lat = 0;
        case (o)
            0, 1, 8, 9, 10, 11: begin
                if (o[0] == 1'b0) p = longint'($signed(a)) * longint'($signed(b));
                else              p = {32'b0, a} * {32'b0, b};
                if (o <= 1) begin
                    {nh, nl} = p;
                    lat = LAT;
                end else begin
`ifdef MUDI_MADD_EN
                    acc = {exp_hi, exp_lo};
                    acc = (o < 10) ? acc + p : acc - p;
                    {nh, nl} = acc;
                    lat = LAT;
`endif
                end
            end
            2, 3: begin
                lat = W;
                if (b == 0) begin
                    nl = 32'hFFFF_FFFF;
                    nh = a;
                end else begin
                    if (o == 2) begin
                        sa = longint'($signed(a)); sb = longint'($signed(b));
                    end else begin
                        sa = longint'({32'b0, a}); sb = longint'({32'b0, b});
                    end
                    q = sa / sb;
                    r = sa % sb;
                    nl = q[31:0];
                    nh = r[31:0];
                end
            end
            4: nh = d;
            5: nl = d;
            default: ;
        endcase
    endtask

    // Issue one op with start for a single cycle and check its full effect.
    task automatic exec(input logic [3:0] o, input logic [31:0] a, b, d);
        logic [31:0] nh, nl;
        int lat, n;
        model_op(o, a, b, d, nh, nl, lat);
        @(negedge Clk);
        start = 1'b1; op = o; A = a; B = b; Din = d;
        @(negedge Clk);
        start = 1'b0;
        n = 0;
        if (lat == 0) begin
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_hi", hi, nh);
            check("idle_lo", lo, nl);
            if (o == 6 || o == 7) check("dout", Dout, (o == 6) ? nh : nl);
        end else begin
            while (busy && n < 100) begin
                check("done_with_busy", done, 0);
                n++;
                @(negedge Clk);
            end
            check("busy_cycles", n, lat);
            check("done_pulse", done, 1);
            check("res_hi", hi, nh);
            check("res_lo", lo, nl);
            @(negedge Clk);
            check("done_clear", done, 0);
        end
        exp_hi = nh; exp_lo = nl;
        $display("op=%0d A=%h B=%h Din=%h -> hi=%h lo=%h busy_cycles=%0d", o, a, b, d, hi, lo, n);
    endtask

    function automatic logic [31:0] rnd_opnd();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'($urandom_range(1, 9));
            4: v = -32'($urandom_range(1, 9));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        Reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = 4'd0;
        A = '0; B = '0; Din = '0;
        exp_hi = 0; exp_lo = 0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        exec(4'd0, -32'd3, 32'd7, 0);
        exec(4'd2, -32'd7, 32'd2, 0);
        exec(4'd3, 32'd7, 32'd0, 0);
        exec(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        exec(4'd4, 0, 0, 32'h1234);
        exec(4'd6, 0, 0, 0);
        exec(4'd4, 0, 0, 32'd5);
        exec(4'd5, 0, 0, 32'd9);

        // Flush in the middle of a divide.
        @(negedge Clk);
        start = 1'b1; op = 4'd2; A = 32'd100; B = 32'd3;
        @(negedge Clk);
        start = 1'b0;
        repeat (9) @(negedge Clk);
        flush = 1'b1;
        @(negedge Clk);
        flush = 1'b0;
        check("flush_mid_busy", busy, 0);
        check("flush_mid_done", done, 0);
        check("flush_mid_hi", hi, 5);
        check("flush_mid_lo", lo, 9);
        @(negedge Clk);
        check("flush_mid_done2", done, 0);

        // Flush on the completing edge.
        start = 1'b1; op = 4'd2; A = 32'd100; B = 32'd3;
        @(negedge Clk);
        start = 1'b0;
        repeat (W - 1) @(negedge Clk);
        check("flush_end_busy_before", busy, 1);
        flush = 1'b1;
        @(negedge Clk);
        flush = 1'b0;
        check("flush_end_busy", busy, 0);
        check("flush_end_done", done, 0);
        check("flush_end_hi", hi, 5);
        check("flush_end_lo", lo, 9);
        @(negedge Clk);
        check("flush_end_done2", done, 0);

        // Start together with flush is dropped.
        start = 1'b1; flush = 1'b1; op = 4'd4; Din = 32'hABCD;
        @(negedge Clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_hi", hi, 5);
        check("flush_start_busy", busy, 0);

        // MTLO while busy is ignored.
        start = 1'b1; op = 4'd0; A = 32'd3; B = 32'd4;
        @(negedge Clk);
        start = 1'b0;
        @(negedge Clk);
        start = 1'b1; op = 4'd5; Din = 32'hDEAD;
        @(negedge Clk);
        start = 1'b0;
        check("mt_busy_lo", lo, 9);
        check("mt_busy_busy", busy, 1);
        for (int i = 0; i < 20 && busy; i++) @(negedge Clk);
        check("mt_busy_done", done, 1);
        check("mt_busy_res_hi", hi, 0);
        check("mt_busy_res_lo", lo, 12);
        exp_hi = 0; exp_lo = 12;

        // Multiply-accumulate carry across HI/LO (no-op without the feature).
        exec(4'd4, 0, 0, 32'd0);
        exec(4'd5, 0, 0, 32'hFFFF_FFFF);
        exec(4'd9, 32'd1, 32'd1, 0);

        // Asynchronous reset in the middle of a multiply.
        exec(4'd4, 0, 0, 32'h55);
        @(negedge Clk);
        start = 1'b1; op = 4'd0; A = 32'd9; B = 32'd9;
        @(negedge Clk);
        start = 1'b0;
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_hi", hi, 0);
        check("async_lo", lo, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        exp_hi = 0; exp_lo = 0;
        exec(4'd0, -32'd3, 32'd7, 0);

        // Randomized op stream.
        for (int i = 0; i < 60; i++) begin
            exec(4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd(), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
